// File: rtl/spatial_filter_pkg.sv
// Shared types and constants for the 3x3 spatial-filter line buffering:
// read-FSM states, buffer/tap counts and the window byte-lane layout.
package spatial_filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  localparam int NUM_LINE_BUFFERS = 4;
  localparam int WINDOW_TAPS      = 3;
  localparam int PIXEL_W          = 8;
  localparam int TAP_W            = WINDOW_TAPS * PIXEL_W;
  localparam int WINDOW_W         = WINDOW_TAPS * TAP_W;

  // First byte lane of each window row inside the 72-bit window.
  localparam int LANE_TOP = 0;
  localparam int LANE_MID = 3;
  localparam int LANE_BOT = 6;

  function automatic logic [1:0] buf_offset(input logic [1:0] base, input logic [1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/line_buffer_row.sv
// One line of pixel storage: single write port, and a 3-tap read returning
// {c+2, c+1, c} with taps past the right edge forced to zero.
module line_buffer_row
  import spatial_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [CW-1:0]      i_wr_col,
  input  logic [PIXEL_W-1:0] i_wr_data,
  input  logic [CW-1:0]      i_rd_col,
  output logic [TAP_W-1:0]   o_tap
);

  localparam logic [CW:0] WIDTH_C = (CW+1)'(IMG_WIDTH);

  logic [PIXEL_W-1:0] r_mem [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_col] <= i_wr_data;
    end
  end

  for (genvar gi = 0; gi < WINDOW_TAPS; gi++) begin : g_tap
    logic [CW:0] w_col;
    assign w_col = {1'b0, i_rd_col} + (CW+1)'(gi);
    assign o_tap[gi*PIXEL_W +: PIXEL_W] = (w_col < WIDTH_C) ? r_mem[w_col[CW-1:0]] : '0;
  end

endmodule

// File: rtl/line_buffer_control.sv
// Round-robin 4-line buffer controller emitting one line of 3x3 windows per read.
// Define LINE_IRQ_EN to build the end-of-line o_intr pulse; otherwise o_intr is 0.
module line_buffer_control
  import spatial_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIXEL_W-1:0]  i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic                o_wr_ready,
  input  logic                i_out_ready,
  output logic [WINDOW_W-1:0] o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_intr
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int OW = $clog2(NUM_LINE_BUFFERS*IMG_WIDTH + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(NUM_LINE_BUFFERS*IMG_WIDTH);
  localparam logic [OW-1:0] OCC_START = OW'(WINDOW_TAPS*IMG_WIDTH);

  logic [CW-1:0]       r_wr_col;
  logic [1:0]          r_wr_idx;
  logic [OW-1:0]       r_occ;
  rd_state_e           r_state;
  logic [CW-1:0]       r_rd_col;
  logic [1:0]          r_base;
  logic [WINDOW_W-1:0] r_pixel_data;
  logic                r_valid;

  logic                w_wr;
  logic                w_rd;
  logic                w_last_col;
  logic [TAP_W-1:0]    w_tap [NUM_LINE_BUFFERS];
  logic [WINDOW_W-1:0] w_window;

  assign o_wr_ready = (r_occ < OCC_FULL);
  assign w_wr       = i_pixel_data_valid && o_wr_ready;
  assign w_rd       = (r_state == READ);
  assign w_last_col = (r_rd_col == LAST_COL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_col <= '0;
      r_wr_idx <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr) begin
        if (r_wr_col == LAST_COL) begin
          r_wr_col <= '0;
          r_wr_idx <= r_wr_idx + 2'd1;
        end else begin
          r_wr_col <= r_wr_col + 1'b1;
        end
      end
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_LINE_BUFFERS; gi++) begin : g_row
    line_buffer_row #(.IMG_WIDTH(IMG_WIDTH)) u_row (
      .clk       (clk),
      .i_wr_en   (w_wr && (r_wr_idx == 2'(gi))),
      .i_wr_col  (r_wr_col),
      .i_wr_data (i_pixel_data),
      .i_rd_col  (r_rd_col),
      .o_tap     (w_tap[gi])
    );
  end

  // The write buffer is never among these three, so no read/write hazard exists.
  assign w_window[LANE_TOP*PIXEL_W +: TAP_W] = w_tap[r_base];
  assign w_window[LANE_MID*PIXEL_W +: TAP_W] = w_tap[buf_offset(r_base, 2'd1)];
  assign w_window[LANE_BOT*PIXEL_W +: TAP_W] = w_tap[buf_offset(r_base, 2'd2)];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rd_col     <= '0;
      r_base       <= '0;
      r_pixel_data <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((r_occ >= OCC_START) && i_out_ready) begin
            r_state  <= READ;
            r_rd_col <= '0;
          end
        end
        READ: begin
          r_valid      <= 1'b1;
          r_pixel_data <= w_window;
          if (w_last_col) begin
            r_state  <= IDLE;
            r_rd_col <= '0;
            r_base   <= r_base + 2'd1;
          end else begin
            r_rd_col <= r_rd_col + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_pixel_data       = r_pixel_data;
  assign o_pixel_data_valid = r_valid;

`ifdef LINE_IRQ_EN
  logic r_intr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= w_rd && w_last_col;
    end
  end

  assign o_intr = r_intr;
`else
  assign o_intr = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_control.sv
// Scoreboard bench for line_buffer_control at IMG_WIDTH=8; o_intr expectations
// follow LINE_IRQ_EN the same way the design build does.
module tb_line_buffer_control;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  i_pixel_data = '0;
  logic        i_pixel_data_valid = 1'b0;
  logic        i_out_ready = 1'b0;
  logic        o_wr_ready;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  always #5 clk = ~clk;

  line_buffer_control #(.IMG_WIDTH(W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_wr_ready         (o_wr_ready),
    .i_out_ready        (i_out_ready),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          run_len = 0;
  int          last_valid_cyc = 0;
  int          last_gap = 0;
  logic [72:0] sb [$];
  logic [72:0] sb_e;
  logic [7:0]  stream [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Expected window for a line whose top row is stream line 'top', column c.
  function automatic logic [71:0] exp_win(input int top, input int c);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        if (c + j < W) w[(r*3+j)*8 +: 8] = stream[(top+r)*W + c + j];
    return w;
  endfunction

  task automatic push_line(input int top);
    logic irq;
    for (int c = 0; c < W; c++) begin
`ifdef LINE_IRQ_EN
      irq = (c == W-1);
`else
      irq = 1'b0;
`endif
      sb.push_back({irq, exp_win(top, c)});
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      run_len = 0;
    end else if (o_pixel_data_valid) begin
      if (run_len == 0) last_gap = cyc - last_valid_cyc;
      run_len++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_valid: got window %0h, required no output", o_pixel_data);
      end else begin
        sb_e = sb.pop_front();
        check("window", o_pixel_data, sb_e[71:0]);
        check("intr", {71'b0, o_intr}, {71'b0, sb_e[72]});
      end
    end else begin
      if (o_intr !== 1'b0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL idle_intr: got %b, required 0", o_intr);
      end
      if (run_len != 0) begin
        check("run_len", 72'(run_len), 72'(W));
        run_len = 0;
      end
    end
  end

  // Called at posedge+1; drives one pixel for exactly one rising edge.
  task automatic wr(input logic [7:0] v, input bit chk_rdy);
    if (chk_rdy) check("wr_ready", {71'b0, o_wr_ready}, 72'd1);
    i_pixel_data       = v;
    i_pixel_data_valid = 1'b1;
    @(posedge clk);
    #1;
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || o_pixel_data_valid) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: got %0d windows pending, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  o_pixel_data, 72'd0);
    check({tag, "_valid"}, {71'b0, o_pixel_data_valid}, 72'd0);
    check({tag, "_intr"},  {71'b0, o_intr}, 72'd0);
    check({tag, "_ready"}, {71'b0, o_wr_ready}, 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First line: pixels 0..23, consumer ready.
    i_out_ready = 1'b1;
    for (int i = 0; i < 24; i++) stream[i] = 8'(i);
    push_line(0);
    for (int i = 0; i < 24; i++) wr(stream[i], 1'b1);
    wait_drain(100);

    // Start a second line, then abort it with reset mid-line.
    for (int i = 0; i < 8; i++) stream[24+i] = 8'(24 + i);
    push_line(1);
    for (int i = 0; i < 8; i++) wr(stream[24+i], 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_valid", {71'b0, o_pixel_data_valid}, 72'd1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("post_rst_ready", {71'b0, o_wr_ready}, 72'd1);

    // After reset nothing comes out until 24 fresh pixels exist.
    for (int i = 0; i < 24; i++) stream[i] = 8'(100 + i);
    for (int i = 0; i < 23; i++) wr(stream[i], 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("no_early_valid", {71'b0, o_pixel_data_valid}, 72'd0);
    end
    push_line(0);
    wr(stream[23], 1'b1);
    wait_drain(100);

    // Fill all four buffers with the consumer stalled.
    do_reset();
    i_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) stream[i] = 8'(i);
    for (int i = 0; i < 32; i++) wr(stream[i], 1'b1);
    check("full_ready", {71'b0, o_wr_ready}, 72'd0);
    wr(8'hAA, 1'b0);
    check("full_ready_hold", {71'b0, o_wr_ready}, 72'd0);
    repeat (20) @(posedge clk);
    #1;

    // Release the stall: two lines, one bubble between them.
    push_line(0);
    push_line(1);
    i_out_ready = 1'b1;
    wait_drain(100);
    check("bubble_gap", 72'(last_gap), 72'd2);

    // Continuous writes while lines are being read.
    do_reset();
    i_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) stream[i] = 8'(i*5 + 1);
    push_line(0);
    push_line(1);
    push_line(2);
    for (int i = 0; i < 40; i++) wr(stream[i], 1'b1);
    wait_drain(200);
    check("sb_empty", 72'(sb.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/line_buffer_control.md
# line_buffer_control

Sequencing controller for the 3x3 spatial-filter datapath. It accepts a raster pixel stream one byte per cycle and stores it round-robin across four line buffers of IMG_WIDTH bytes each. Once three full lines are held and the consumer is ready, it reads a complete line of 3x3 windows, one per cycle. It sits between the input stream interface and the convolution stage, whose 72-bit window input it drives directly.

## Interface
- IMG_WIDTH, 512, pixels per line; must be at least 4.
- clk  in  1  clock; everything samples on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pixel_data  in  8  input pixel.
- i_pixel_data_valid  in  1  write strobe.
- o_wr_ready  out  1  high while buffer occupancy is below 4*IMG_WIDTH.
- i_out_ready  in  1  consumer may accept a line of windows.
- o_pixel_data  out  72  3x3 window. Byte k = [8k+:8]. Bytes 0-2: top row, columns c..c+2. Bytes 3-5: middle row. Bytes 6-8: bottom row.
- o_pixel_data_valid  out  1  window valid.
- o_intr  out  1  one-cycle pulse per line consumed (see Configuration).

## Operation
- Write side:
  - A write occurs when i_pixel_data_valid && o_wr_ready. Valid while not ready: the pixel is dropped and state is unchanged.
  - Write column counter runs 0..IMG_WIDTH-1. On wrap, the write-buffer index advances mod 4.
- Occupancy counter:
  - Width $clog2(4*IMG_WIDTH+1).
  - +1 per accepted write; -1 per READ cycle; both in the same cycle leaves it unchanged.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when occupancy >= 3*IMG_WIDTH && i_out_ready.
  - READ lasts exactly IMG_WIDTH cycles, columns c=0..IMG_WIDTH-1, and is not interruptible by i_out_ready.
  - After the last column: READ -> IDLE, and the read base index advances mod 4.
- Row mapping: top = buffer base; middle = base+1; bottom = base+2 (all mod 4).
- Column taps c+1 and c+2 at or beyond IMG_WIDTH read as 0 (right zero padding).
- The write buffer is never one of the three read buffers. This is guaranteed by the occupancy limit of 4*IMG_WIDTH.
- Reset values:
  - o_pixel_data = 0, o_pixel_data_valid = 0, o_intr = 0; o_wr_ready = 1 after reset.
  - Counters = 0, base = 0, write index = 0, FSM = IDLE.
  - Buffer contents are not reset.
- Reset asserted mid-line aborts the line immediately. All state returns to reset values; stored pixels are discarded.

## Timing
- Output is registered: each READ cycle for column c produces o_pixel_data_valid = 1 on the next cycle.
- Each line gives IMG_WIDTH consecutive valid cycles.
- There is at least one idle (bubble) cycle between lines.
- o_intr coincides with the last valid window of the line.
- Write-to-storage takes 1 cycle. Occupancy reflects a write on the following cycle.
- o_wr_ready is combinational from the registered occupancy.

## Configuration
- LINE_IRQ_EN defined: o_intr pulses high for one cycle at the end of each line read.
- LINE_IRQ_EN undefined: o_intr is tied to 0 and its pulse register is not built.

## Structure
- Package spatial_filter_pkg holds:
  - the read-FSM state typedef (IDLE, READ);
  - NUM_LINE_BUFFERS = 4 and WINDOW_TAPS = 3;
  - the window byte-lane constants.
- Sub-module line_buffer_row (instantiated 4x) provides:
  - an IMG_WIDTH x 8 storage array with a write port (enable, column);
  - a read column input returning the 24-bit tap {c+2, c+1, c} with zero padding.
- The top level holds the counters, the FSM, the row multiplexing and the output registers.

## Test plan
All scenarios use IMG_WIDTH=8.
- Reset: assert reset_n=0 mid-stream -> all outputs 0 within the same cycle, o_wr_ready=1 after release, no valid until 24 new pixels are written.
- First line: write pixels 0..23 with i_out_ready=1 -> 8 valid windows.
  - First window = {18,17,16,10,9,8,2,1,0}, listed from byte 8 down to byte 0.
  - Last window = {0,0,23,0,0,15,0,0,7}.
  - o_intr is high on the 8th valid only.
- Full: i_out_ready=0, write 33 pixels -> o_wr_ready drops after the 32nd, the 33rd is dropped, no valid output.
- Stall release: from full, raise i_out_ready -> line read with top row pixels 0..7, base=1. Occupancy reaches 24 and the next line starts after one bubble cycle.
- Simultaneous write/read: continuous writes during READ -> occupancy constant at 24, no dropped pixels, and the second line's top row is pixels 8..15.
- Configuration: build without LINE_IRQ_EN, rerun first-line -> o_intr stays 0 and windows are identical.
